// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: button-driven grid cursor with hold-to-repeat and a mark/stab command handshake
module grid_cursor_ctrl #(
  parameter int ROWS       = 6,
  parameter int COLS       = 6,
  parameter int PW         = 6,
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4,
  parameter int WRAP       = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          mark,
  input  logic          stab,
  output logic [PW-1:0] pointer,
  output logic [3:0]    row,
  output logic [3:0]    col,
  output logic          cmd_valid,
  output logic          cmd_type,
  output logic [PW-1:0] cmd_pos,
  input  logic          cmd_ready,
  output logic          cmd_drop
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;
  localparam logic [3:0] RMAX = 4'(ROWS - 1);
  localparam logic [3:0] CMAX = 4'(COLS - 1);
  localparam logic [15:0] DLY_M1 = 16'(REPEAT_DLY - 1);
  localparam logic [15:0] PER_M1 = 16'(REPEAT_PER - 1);
  localparam logic WR = (WRAP != 0);
  state_t state_q, state_d;
  logic [5:0] raw, btn_q;
  logic [3:0] dir_q, dir_d, row_q, row_d, col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic cmd_valid_q, cmd_valid_d, cmd_type_q, cmd_type_d, cmd_drop_q, cmd_drop_d;
  logic [PW-1:0] cmd_pos_q, cmd_pos_d;
  logic single, mv, issue, can_issue;
  assign raw = {stab, mark, right, left, down, up};
  assign single = (btn_q != 6'd0) && ((btn_q & (btn_q - 6'd1)) == 6'd0);
  assign can_issue = !cmd_valid_q || cmd_ready;
  assign pointer = PW'(int'(row_q) * COLS + int'(col_q));
  assign row = row_q;
  assign col = col_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_type = cmd_type_q;
  assign cmd_pos = cmd_pos_q;
  assign cmd_drop = cmd_drop_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    mv = 1'b0;
    issue = 1'b0;
    cmd_drop_d = 1'b0;
    if (state_q == IDLE) begin
      if (single && |btn_q[3:0]) begin
        mv = 1'b1;
        dir_d = btn_q[3:0];
        cnt_d = '0;
        state_d = DELAY;
      end else if (single) begin
        issue = can_issue;
        cmd_drop_d = !can_issue;
        state_d = LOCK;
      end else if (|btn_q) state_d = LOCK;
    end else if (state_q == LOCK) begin
      if (!(|btn_q) && !(|raw)) state_d = IDLE;
    end else if (btn_q != {2'b00, dir_q}) begin
      state_d = |btn_q ? LOCK : IDLE;
    end else if (cnt_q == (state_q == DELAY ? DLY_M1 : PER_M1)) begin
      mv = 1'b1;
      cnt_d = '0;
      state_d = REPEAT;
    end else cnt_d = cnt_q + 16'd1;
  end
  // moves only fire while btn_q holds exactly the captured direction, so btn_q selects it
  always_comb begin
    row_d = !mv ? row_q
          : btn_q[0] ? (row_q == 4'd0 ? (WR ? RMAX : 4'd0) : row_q - 4'd1)
          : btn_q[1] ? (row_q == RMAX ? (WR ? 4'd0 : RMAX) : row_q + 4'd1)
          : row_q;
    col_d = !mv ? col_q
          : btn_q[2] ? (col_q == 4'd0 ? (WR ? CMAX : 4'd0) : col_q - 4'd1)
          : btn_q[3] ? (col_q == CMAX ? (WR ? 4'd0 : CMAX) : col_q + 4'd1)
          : col_q;
    cmd_valid_d = issue ? 1'b1 : (cmd_valid_q && cmd_ready) ? 1'b0 : cmd_valid_q;
    cmd_type_d = issue ? btn_q[5] : cmd_type_q;
    cmd_pos_d = issue ? pointer : cmd_pos_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCK;
      btn_q <= '0;
      cnt_q <= '0;
      dir_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q <= 1'b0;
      cmd_pos_q <= '0;
      cmd_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q <= raw;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      row_q <= row_d;
      col_q <= col_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q <= cmd_type_d;
      cmd_pos_q <= cmd_pos_d;
      cmd_drop_q <= cmd_drop_d;
    end
  end
endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb_grid_cursor_ctrl: random button traffic on a clamping and a wrapping instance, checked against a hold-time model
module tb_grid_cursor_ctrl;
  localparam int RS[2] = '{6, 5};
  localparam int CS[2] = '{6, 7};
  localparam int DL[2] = '{8, 3};
  localparam int PR[2] = '{4, 2};
  localparam int WR[2] = '{0, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] raw = '0;
  logic cmd_ready = 1'b0;
  logic [5:0] d_ptr[2], d_pos[2];
  logic [3:0] d_row[2], d_col[2];
  logic d_v[2], d_t[2], d_drop[2];
  int n_chk = 0, n_pass = 0;
  int m_row[2], m_col[2], m_hold[2], m_pos[2];
  bit m_lock[2], m_v[2], m_t[2], m_drop[2];
  logic [5:0] m_dir[2];
  logic [5:0] m_btn = '0;
  always #5 clk = ~clk;
  grid_cursor_ctrl #(.ROWS(6), .COLS(6), .PW(6), .REPEAT_DLY(8), .REPEAT_PER(4), .WRAP(0)) u_clamp (
    .clk(clk), .rst(rst), .up(raw[0]), .down(raw[1]), .left(raw[2]), .right(raw[3]),
    .mark(raw[4]), .stab(raw[5]), .pointer(d_ptr[0]), .row(d_row[0]), .col(d_col[0]),
    .cmd_valid(d_v[0]), .cmd_type(d_t[0]), .cmd_pos(d_pos[0]), .cmd_ready(cmd_ready), .cmd_drop(d_drop[0]));
  grid_cursor_ctrl #(.ROWS(5), .COLS(7), .PW(6), .REPEAT_DLY(3), .REPEAT_PER(2), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .up(raw[0]), .down(raw[1]), .left(raw[2]), .right(raw[3]),
    .mark(raw[4]), .stab(raw[5]), .pointer(d_ptr[1]), .row(d_row[1]), .col(d_col[1]),
    .cmd_valid(d_v[1]), .cmd_type(d_t[1]), .cmd_pos(d_pos[1]), .cmd_ready(cmd_ready), .cmd_drop(d_drop[1]));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask
  // hold time since the first move decides repeats: moves at 0, DLY, DLY+PER, DLY+2*PER, ...
  task automatic step(input int k);
    logic [5:0] b;
    logic [3:0] mv;
    bit issue, w;
    int ptr;
    b = m_btn;
    mv = '0;
    issue = 0;
    w = WR[k] != 0;
    ptr = m_row[k] * CS[k] + m_col[k];
    m_drop[k] = 0;
    if (rst) begin
      m_row[k] = 0; m_col[k] = 0; m_v[k] = 0; m_t[k] = 0; m_pos[k] = 0;
      m_lock[k] = 1; m_hold[k] = -1; m_dir[k] = '0;
      return;
    end
    if (m_lock[k]) begin
      if (b == 0 && raw == 0) m_lock[k] = 0;
    end else if (m_hold[k] >= 0) begin
      if (b == m_dir[k]) begin
        m_hold[k]++;
        if (m_hold[k] == DL[k] || (m_hold[k] > DL[k] && (m_hold[k] - DL[k]) % PR[k] == 0)) mv = b[3:0];
      end else begin
        m_hold[k] = -1;
        m_lock[k] = (b != 0);
      end
    end else if (b != 0) begin
      if ($countones(b) == 1 && b[3:0] != 0) begin
        mv = b[3:0]; m_hold[k] = 0; m_dir[k] = b;
      end else begin
        m_lock[k] = 1;
        if ($countones(b) == 1) begin
          if (!m_v[k] || cmd_ready) issue = 1;
          else m_drop[k] = 1;
        end
      end
    end
    if (issue) begin
      m_v[k] = 1; m_t[k] = b[5]; m_pos[k] = ptr;
    end else if (m_v[k] && cmd_ready) m_v[k] = 0;
    if (mv[0]) m_row[k] = m_row[k] == 0 ? (w ? RS[k] - 1 : 0) : m_row[k] - 1;
    if (mv[1]) m_row[k] = m_row[k] == RS[k] - 1 ? (w ? 0 : RS[k] - 1) : m_row[k] + 1;
    if (mv[2]) m_col[k] = m_col[k] == 0 ? (w ? CS[k] - 1 : 0) : m_col[k] - 1;
    if (mv[3]) m_col[k] = m_col[k] == CS[k] - 1 ? (w ? 0 : CS[k] - 1) : m_col[k] + 1;
  endtask
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) step(k);
    m_btn = rst ? 6'd0 : raw;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("row%0d", k), d_row[k], m_row[k]);
      chk($sformatf("col%0d", k), d_col[k], m_col[k]);
      chk($sformatf("pointer%0d", k), d_ptr[k], m_row[k] * CS[k] + m_col[k]);
      chk($sformatf("cmd_valid%0d", k), d_v[k], m_v[k]);
      chk($sformatf("cmd_type%0d", k), d_t[k], m_t[k]);
      chk($sformatf("cmd_pos%0d", k), d_pos[k], m_pos[k]);
      chk($sformatf("cmd_drop%0d", k), d_drop[k], m_drop[k]);
    end
  endtask
  initial begin
    int r, len;
    logic [5:0] pat;
    raw = 6'b001000;
    tick();
    chk("reset_pointer", d_ptr[0], 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    raw = '0;
    repeat (2) tick();
    raw = 6'b001000;
    repeat (2) tick();
    raw = '0;
    repeat (2) tick();
    chk("first_move_col", d_col[0], 1);
    repeat (200) begin
      r = $urandom_range(0, 9);
      pat = r <= 5 ? 6'(1 << $urandom_range(0, 3))
          : r == 6 ? 6'b010000
          : r == 7 ? 6'b100000
          : r == 8 ? 6'($urandom)
          : 6'(1 << $urandom_range(0, 1)) | 6'(4 << $urandom_range(0, 1));
      len = $urandom_range(1, 30);
      raw = pat;
      repeat (len) begin
        cmd_ready = $urandom_range(0, 9) < 3;
        rst = $urandom_range(0, 299) == 0;
        tick();
      end
      rst = 1'b0;
      raw = '0;
      repeat ($urandom_range(0, 3)) begin
        cmd_ready = $urandom_range(0, 9) < 3;
        tick();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/grid_cursor_ctrl.md
# grid_cursor_ctrl

Parametrised cursor and command front-end for the grid game engine. Converts raw level buttons (up/down/left/right/mark/stab) into single-step cursor moves with hold-to-repeat, edge clamp or wrap-around, and mark/stab commands issued to the play engine over a valid/ready handshake. It sits between the board's button inputs and the game engine, replacing ad-hoc enable/lock registers in the top level.

## Interface
Parameters:
- ROWS, 6, grid rows (2..16)
- COLS, 6, grid columns (2..16)
- PW, 6, pointer width; must satisfy 2^PW >= ROWS*COLS
- REPEAT_DLY, 8, cycles a direction is held after the first move before auto-repeat starts (>=1)
- REPEAT_PER, 4, cycles between auto-repeat moves (>=1)
- WRAP, 0, 0 = clamp at edges, 1 = wrap to opposite edge

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- up, down, left, right, mark, stab  in  1 each  button levels, already synchronised to clk
- pointer  out  PW  linear cursor index = row*COLS + col, combinational from row/col registers
- row  out  4  cursor row, 0..ROWS-1
- col  out  4  cursor column, 0..COLS-1
- cmd_valid  out  1  command pending
- cmd_type  out  1  0 = mark, 1 = stab
- cmd_pos  out  PW  pointer captured when command issued
- cmd_ready  in  1  engine accepts command
- cmd_drop  out  1  one-cycle pulse: mark/stab press discarded because a command was pending

## Operation
- Input stage: six buttons registered into btn_q every cycle; FSM acts on btn_q only (except LOCK exit, below).
- "Single press" = exactly one bit of btn_q set; any other non-zero btn_q is a multi-press.
- FSM states: IDLE, DELAY, REPEAT, LOCK. A 16-bit counter cnt serves DELAY and REPEAT.
- IDLE: btn_q==0 -> stay. Single direction -> move once, capture direction, cnt=0, -> DELAY. Single mark/stab -> issue command (if allowed), -> LOCK. Multi-press -> LOCK, no action.
- DELAY: btn_q != captured direction -> LOCK (IDLE if btn_q==0). Else cnt==REPEAT_DLY-1 -> move, cnt=0, -> REPEAT; otherwise cnt+1.
- REPEAT: same exit rule as DELAY. cnt==REPEAT_PER-1 -> move, cnt=0; otherwise cnt+1.
- LOCK: no actions; -> IDLE only when btn_q==0 and all six raw inputs ==0.
- Move: up row-1, down row+1, left col-1, right col+1. At an edge: WRAP=0 holds the value; WRAP=1 goes 0<->ROWS-1 / 0<->COLS-1. Row and column never leave range.
- Command issue: allowed when cmd_valid==0 or (cmd_valid && cmd_ready) in that cycle (back-to-back). Sets cmd_valid=1, cmd_type, cmd_pos=pointer (pre-update value; commands never move the cursor). If not allowed: pending command untouched, cmd_drop=1 for one cycle.
- Handshake: cmd_type/cmd_pos stable while cmd_valid=1; cmd_valid clears at the edge where cmd_valid && cmd_ready, unless a new command is issued in the same edge.
- Cursor moves continue while a command is pending; cmd_pos is not affected.

## Timing
- Reset values: row=0, col=0, pointer=0, cmd_valid=0, cmd_type=0, cmd_pos=0, cmd_drop=0, btn_q=0, cnt=0, state=LOCK.
- Because state resets to LOCK, buttons held through reset do nothing until fully released.
- Button high before edge E: btn_q set at E; row/col/cmd_valid update at E+1; pointer follows combinationally.
- First auto-repeat move lands REPEAT_DLY cycles after the first move; later moves every REPEAT_PER cycles.
- Releasing a direction for one cycle and pressing again gives a new first move. Switching direction without release goes to LOCK, so no move happens.
- rst asserted mid-operation: all state reset at that edge; a pending command is lost without handshake.

## Test plan
- Reset, press right 1 cycle, release: col 0->1 two edges after press, pointer=1; no further moves.
- ROWS=COLS=6, WRAP=0, cursor (0,0), press up: row stays 0. With WRAP=1: row=5, pointer=30.
- Hold down 30 cycles, REPEAT_DLY=8, REPEAT_PER=4: moves at hold offsets 0, 8, 12, 16, 20, 24, 28; row clamps at 5 with WRAP=0.
- Press up+left together: no movement; release, press left: col-1 exactly once.
- Cursor at pointer 14, cmd_ready=0: press stab -> cmd_valid=1, cmd_type=1, cmd_pos=14. Press mark -> cmd_drop pulse, outputs unchanged. Raise cmd_ready -> cmd_valid=0 next edge.
- Hold right through rst: no move after reset until right is released and pressed again. Assert rst while cmd_valid=1: cmd_valid=0 and pointer=0 next edge.
